// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of a pipelined SRAM controller, routing read data back in issue order.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of favouring m0.
module sram_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     s_address,
    output logic [DATA_W/8-1:0]   s_byteenable,
    output logic                  s_chipselect,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    input  logic [DATA_W-1:0]     s_readdata
);

    logic                    req0;
    logic                    req1;
    logic                    gnt_valid;
    logic                    gnt_id;
    logic                    sel_read;
    logic                    sel_write;
    logic                    push;
    logic [READ_LATENCY-1:0] rd_vld;
    logic [READ_LATENCY-1:0] rd_id;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (gnt_valid) begin
            last_grant <= gnt_id;
        end
    end
`endif

    // Reset forces no grant so nothing is accepted or forwarded while it is held.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt_valid = 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                gnt_id    = ~last_grant;
`else
                gnt_id    = 1'b0;
`endif
            end else if (req0) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req1) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign sel_read  = gnt_id ? m1_read  : m0_read;
    assign sel_write = gnt_id ? m1_write : m0_write;

    // A combined read+write is forwarded as a write only and never expects data back.
    assign push = gnt_valid & sel_read & ~sel_write;

    assign s_chipselect = gnt_valid;
    assign s_write      = gnt_valid & sel_write;
    assign s_read       = push;
    assign s_address    = gnt_id ? m1_address    : m0_address;
    assign s_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
    assign s_writedata  = gnt_id ? m1_writedata  : m0_writedata;

    assign m0_waitrequest = ~(gnt_valid & ~gnt_id);
    assign m1_waitrequest = ~(gnt_valid &  gnt_id);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld <= '0;
            rd_id  <= '0;
        end else begin
            rd_vld[0] <= push;
            rd_id[0]  <= gnt_id;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_id[i]  <= rd_id[i-1];
            end
        end
    end

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = rd_vld[READ_LATENCY-1] & ~rd_id[READ_LATENCY-1] & ~reset;
    assign m1_readdatavalid = rd_vld[READ_LATENCY-1] &  rd_id[READ_LATENCY-1] & ~reset;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: per-cycle reference model plus directed scenario checks.
module tb_sram_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int BE_W   = DATA_W / 8;
    localparam int LAT    = 2;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
    logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
    logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [DATA_W-1:0] s_readdata = '0;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic [BE_W-1:0]   s_byteenable;
    logic              s_chipselect, s_read, s_write;
    logic [DATA_W-1:0] s_writedata;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_chipselect(s_chipselect),
        .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: pending read returns are (due cycle, master) pairs; ties follow the winner history.
    int due_q[$];
    bit id_q[$];
    bit model_last = 1'b1;

    always @(negedge clk) begin
        bit r0, r1, g, gid, is_wr, is_rd, e0, e1;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        g  = !reset && (r0 || r1);
        if (r0 && r1) gid = RR ? !model_last : 1'b0;
        else          gid = !r0;
        is_wr = gid ? m1_write : m0_write;
        is_rd = (gid ? m1_read : m0_read) && !is_wr;
        e0 = 1'b0;
        e1 = 1'b0;
        foreach (due_q[i]) begin
            if (due_q[i] == cyc) begin
                if (id_q[i]) e1 = 1'b1;
                else         e0 = 1'b1;
            end
        end
        if (reset) begin
            e0 = 1'b0;
            e1 = 1'b0;
        end

        check("m0_waitrequest", m0_waitrequest, !(g && !gid));
        check("m1_waitrequest", m1_waitrequest, !(g && gid));
        check("s_chipselect", s_chipselect, g);
        check("s_read", s_read, g && is_rd);
        check("s_write", s_write, g && is_wr);
        if (g) begin
            check("s_address", s_address, gid ? m1_address : m0_address);
            check("s_byteenable", s_byteenable, gid ? m1_byteenable : m0_byteenable);
            check("s_writedata", s_writedata, gid ? m1_writedata : m0_writedata);
        end
        check("m0_readdatavalid", m0_readdatavalid, e0);
        check("m1_readdatavalid", m1_readdatavalid, e1);
        check("m0_readdata", m0_readdata, s_readdata);
        check("m1_readdata", m1_readdata, s_readdata);

        if (reset) begin
            due_q.delete();
            id_q.delete();
            model_last = 1'b1;
        end else begin
            for (int i = due_q.size() - 1; i >= 0; i--) begin
                if (due_q[i] <= cyc) begin
                    due_q.delete(i);
                    id_q.delete(i);
                end
            end
            if (g && is_rd) begin
                due_q.push_back(cyc + LAT);
                id_q.push_back(gid);
            end
            if (g) model_last = gid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        s_readdata = DATA_W'(cyc * 13 + 'h5A00);
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    initial begin
        // Reset held with m0 requesting: nothing may be granted.
        reset = 1'b1;
        m0_read = 1'b1;
        @(negedge clk);
        check("rst m0_waitrequest", m0_waitrequest, 1'b1);
        check("rst m1_waitrequest", m1_waitrequest, 1'b1);
        check("rst s_chipselect", s_chipselect, 1'b0);
        check("rst s_read", s_read, 1'b0);
        step();
        step();
        idle();
        reset = 1'b0;

        // Both masters reading at once, starting right after reset.
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                m0_read = 1'b1; m0_address = ADDR_W'(k);
                m1_read = 1'b1; m1_address = ADDR_W'(k + 'h100);
            end else begin
                idle();
            end
            @(negedge clk);
            if (k < 6) begin
                if (RR) begin
                    check("rr m0_waitrequest", m0_waitrequest, (k % 2) == 1);
                    check("rr m1_waitrequest", m1_waitrequest, (k % 2) == 0);
                end else begin
                    check("fp m0_waitrequest", m0_waitrequest, 1'b0);
                    check("fp m1_waitrequest", m1_waitrequest, 1'b1);
                end
            end
            if (k >= 2) begin
                if (RR) check("rr m0_readdatavalid", m0_readdatavalid, ((k - 2) % 2) == 0);
                else    check("fp m1_readdatavalid", m1_readdatavalid, 1'b0);
            end
            step();
        end
        idle();
        step();

        // Single m0 read, data returned two cycles later.
        m0_read = 1'b1; m0_address = 18'h00010; m0_byteenable = 2'b11;
        @(negedge clk);
        check("rd m0_waitrequest", m0_waitrequest, 1'b0);
        check("rd s_address", s_address, 18'h00010);
        step();
        idle();
        @(negedge clk);
        check("rd early m0_readdatavalid", m0_readdatavalid, 1'b0);
        step();
        s_readdata = 16'hBEEF;
        @(negedge clk);
        check("rd m0_readdatavalid", m0_readdatavalid, 1'b1);
        check("rd m0_readdata", m0_readdata, 16'hBEEF);
        check("rd m1_readdatavalid", m1_readdatavalid, 1'b0);
        step();

        // Alternating single reads: m0, m1, m0 with no bubbles.
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k == 0 || k == 2) m0_read = 1'b1;
            if (k == 1)           m1_read = 1'b1;
            @(negedge clk);
            if (k >= 2) begin
                check("alt m0_readdatavalid", m0_readdatavalid, k != 3);
                check("alt m1_readdatavalid", m1_readdatavalid, k == 3);
            end
            step();
        end
        idle();

        // m1 partial write at top of address space.
        m1_write = 1'b1; m1_address = 18'h3FFFF; m1_byteenable = 2'b10; m1_writedata = 16'h1234;
        @(negedge clk);
        check("wr s_write", s_write, 1'b1);
        check("wr s_read", s_read, 1'b0);
        check("wr s_address", s_address, 18'h3FFFF);
        check("wr s_byteenable", s_byteenable, 2'b10);
        check("wr s_writedata", s_writedata, 16'h1234);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wr m1_readdatavalid", m1_readdatavalid, 1'b0);
            step();
        end

        // m0 read and write together: write only, no data return.
        m0_read = 1'b1; m0_write = 1'b1; m0_writedata = 16'hCAFE;
        @(negedge clk);
        check("rw s_write", s_write, 1'b1);
        check("rw s_read", s_read, 1'b0);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rw m0_readdatavalid", m0_readdatavalid, 1'b0);
            step();
        end

        // Read in flight killed by a one-cycle reset; m1 arbitrates on the first cycle after.
        m0_read = 1'b1; m0_address = 18'h00ABC;
        step();
        idle();
        reset = 1'b1;
        m1_read = 1'b1;
        @(negedge clk);
        check("rst2 m1_waitrequest", m1_waitrequest, 1'b1);
        check("rst2 s_chipselect", s_chipselect, 1'b0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post-rst m1_waitrequest", m1_waitrequest, 1'b0);
        check("post-rst m0_readdatavalid", m0_readdatavalid, 1'b0);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post-rst m0_readdatavalid", m0_readdatavalid, 1'b0);
            step();
        end

        // Mixed traffic with occasional reset; the model checks every cycle.
        for (int k = 0; k < 80; k++) begin
            m0_read       = 1'($urandom_range(0, 1));
            m0_write      = ($urandom_range(0, 3) == 0);
            m1_read       = 1'($urandom_range(0, 1));
            m1_write      = ($urandom_range(0, 3) == 0);
            m0_address    = ADDR_W'($urandom);
            m1_address    = ADDR_W'($urandom);
            m0_byteenable = BE_W'($urandom);
            m1_byteenable = BE_W'($urandom);
            m0_writedata  = DATA_W'($urandom);
            m1_writedata  = DATA_W'($urandom);
            reset         = ($urandom_range(0, 19) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        repeat (LAT + 2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
